peripheral_mult_gen: RTL and testbench
======================================

// Module: peripheral_mult_gen
// PURPOSE
//  Parametrised memory-mapped multiplier peripheral on the J1 I/O bus; next generation of the fixed 16-bit multiplier peripheral.
//  Adds generic operand width, signed/unsigned mode, busy/done status, sticky done, interrupt output and a split 2*OP_W result readout.
//  Contains its own sequential shift-add multiplier core; sits behind the I/O address decoder alongside other peripherals.
// PARAMETERS
//  DATA_W  32  bus data width of d_in/d_out
//  OP_W    16  operand width; legal 2..DATA_W; result width RES_W = 2*OP_W
// PORTS
//  clk     in   1       system clock, all state on rising edge
//  reset   in   1       asynchronous, active-low reset (asserted when 0)
//  d_in    in   DATA_W  write data
//  cs      in   1       peripheral select
//  addr    in   5       register address (low bits of j1_io_addr)
//  rd      in   1       read strobe, qualified by cs
//  wr      in   1       write strobe, qualified by cs
//  d_out   out  DATA_W  registered read data
//  irq     out  1       level interrupt = done & CTRL.ie
// BEHAVIOUR
//  Reset (reset=0, async): A, B, CTRL, result, done, busy, start pulse, d_out, irq all 0; core FSM -> IDLE.
//  Register map (write = cs&wr, read = cs&rd; unmapped writes ignored, unmapped reads return 0):
//   0x04 A       RW  operand A = d_in[OP_W-1:0]
//   0x08 B       RW  operand B = d_in[OP_W-1:0]
//   0x0C CTRL    W   bit0 start (self-clearing pulse, reads 0), bit1 sgn (1=two's complement), bit2 ie; reads {ie,sgn,0}
//   0x10 RES_LO  R   result[DATA_W-1:0]
//   0x14 STATUS  R   {busy,done} in bits[1:0]
//   0x18 RES_HI  R   result >> DATA_W, zero-filled (all 0 when RES_WDATA_W)
//  Read latency: d_out updates on the edge sampling cs&rd; d_out holds its value when no read is active.
//  Start: a CTRL write with bit0=1 at edge E0 sets start_q. If the core is idle, done clears at E0 and
//   the core loads A, B, sgn at E1 (busy=1, IDLE->CALC). After OP_W CALC cycles it goes CALC->FIN.
//   The FIN cycle applies the sign, writes result, sets done=1 and busy=0, and goes FIN->IDLE.
//   result/done are visible at E0+OP_W+2 (18 cycles for OP_W=16).
//  Arithmetic, signed mode: magnitudes |A|, |B| are OP_W-bit unsigned (|-2^(OP_W-1)| fits).
//   The product is negated when sign(A)^sign(B); zero operand -> result 0, never -0 issues.
//  Unsigned mode: plain OP_W x OP_W -> RES_W product; no overflow is possible.
//  Start while busy: ignored (no restart, done unaffected, CTRL sgn/ie bits still updated).
//  Writes to A/B while busy: registers update, running operation unaffected (operands were captured at E1).
//  done is sticky until the next accepted start; result holds until overwritten at the next FIN.
//  Simultaneous read of STATUS in FIN cycle returns pre-edge value (busy=1, done=0).
//  Reset mid-operation: core returns to IDLE immediately; result/done cleared.
// STRUCTURE
//  Package peripheral_mult_pkg: address localparams (ADDR_A..ADDR_RES_HI), CTRL bit indices (START, SGN, IE), STATUS bit indices, core FSM state encoding (IDLE/CALC/FIN).
//  Sub-module mult_seq (params OP_W): clk, reset, start, sgn, op_a, op_b -> busy, done_p (1-cycle), result[RES_W].
//   It holds the FSM, shift-add datapath and iteration counter ($clog2(OP_W+1) bits).
//  The top holds the address decode, registers, sticky done, read mux and irq.
// TESTING
//  1 OP_W=16, sgn=0: A=3, B=5, start -> STATUS=0b10 during run; at E0+18 RES_LO=0x0000000F, STATUS=0b01.
//  2 OP_W=16, sgn=1: A=0xFFFD, B=5 -> RES_LO=0xFFFFFFF1; A=B=0x8000 -> RES_LO=0x40000000; A=0, B=0x8000 -> 0.
//  3 OP_W=32, sgn=0: A=B=0xFFFFFFFF -> RES_LO=0x00000001, RES_HI=0xFFFFFFFE; sgn=1 same operands -> RES_LO=1, RES_HI=0.
//  4 Start A=7,B=9; at E0+5 write A=2 and re-start -> result 63, done at original time only; STATUS=0b01 afterwards.
//  5 ie=1, run 3*5 -> irq rises with done; new start -> irq drops at E0; reset=0 mid-CALC -> busy,done,irq,d_out=0 asynchronously.
//  6 Read unmapped 0x1C and CTRL -> 0 / {ie,sgn,0}; read with cs=0 -> d_out unchanged; write with cs=0 -> no register change.

Source files
------------

// File: rtl/peripheral_mult_pkg.sv
// Shared definitions for the memory-mapped multiplier peripheral: register map,
// CTRL/STATUS bit positions and the core FSM encoding.
package peripheral_mult_pkg;
    localparam logic [4:0] ADDR_A      = 5'h04;
    localparam logic [4:0] ADDR_B      = 5'h08;
    localparam logic [4:0] ADDR_CTRL   = 5'h0C;
    localparam logic [4:0] ADDR_RES_LO = 5'h10;
    localparam logic [4:0] ADDR_STATUS = 5'h14;
    localparam logic [4:0] ADDR_RES_HI = 5'h18;

    localparam int CTRL_START = 0;
    localparam int CTRL_SGN   = 1;
    localparam int CTRL_IE    = 2;

    localparam int STAT_DONE = 0;
    localparam int STAT_BUSY = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2
    } mult_state_e;
endpackage

// File: rtl/mult_seq.sv
// Sequential shift-add multiplier: sign-magnitude operands, OP_W add/shift
// iterations, then one FIN cycle that applies the sign and latches the result.
module mult_seq
    import peripheral_mult_pkg::*;
#(
    parameter int OP_W  = 16,
    parameter int RES_W = 2 * OP_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sgn,
    input  logic [OP_W-1:0]  op_a,
    input  logic [OP_W-1:0]  op_b,
    output logic             busy,
    output logic             done_p,
    output logic [RES_W-1:0] result
);
    localparam int CW = $clog2(OP_W + 1);

    mult_state_e      state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [OP_W-1:0]  ma_q, ma_d;
    logic [RES_W-1:0] prod_q, prod_d;
    logic             neg_q, neg_d;
    logic [RES_W-1:0] result_q, result_d;
    logic [OP_W:0]    sum;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            ma_q     <= '0;
            prod_q   <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ma_q     <= ma_d;
            prod_q   <= prod_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ma_d     = ma_q;
        prod_d   = prod_q;
        neg_d    = neg_q;
        result_d = result_q;
        sum      = {1'b0, prod_q[RES_W-1:OP_W]} + (prod_q[0] ? {1'b0, ma_q} : '0);
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Magnitude of -2^(OP_W-1) still fits in OP_W unsigned bits.
                    ma_d    = (sgn && op_a[OP_W-1]) ? -op_a : op_a;
                    prod_d  = {{OP_W{1'b0}}, ((sgn && op_b[OP_W-1]) ? -op_b : op_b)};
                    neg_d   = sgn && (op_a[OP_W-1] ^ op_b[OP_W-1]);
                    cnt_d   = '0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                prod_d = {sum, prod_q[OP_W-1:1]};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(OP_W - 1)) state_d = ST_FIN;
            end
            ST_FIN: begin
                result_d = neg_q ? -prod_q : prod_q;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy   = (state_q != ST_IDLE);
    assign done_p = (state_q == ST_FIN);
    assign result = result_q;
endmodule

// File: rtl/peripheral_mult_gen.sv
// J1 I/O-bus multiplier peripheral: register file, address decode, sticky done,
// registered read mux and level interrupt around the mult_seq core.
module peripheral_mult_gen
    import peripheral_mult_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OP_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] d_in,
    input  logic              cs,
    input  logic [4:0]        addr,
    input  logic              rd,
    input  logic              wr,
    output logic [DATA_W-1:0] d_out,
    output logic              irq
);
    localparam int RES_W = 2 * OP_W;

    logic [OP_W-1:0]   a_q, a_d, b_q, b_d;
    logic              sgn_q, sgn_d, ie_q, ie_d;
    logic              start_q, start_d, done_q, done_d;
    logic [DATA_W-1:0] d_out_q, d_out_d, rdata;
    logic              wr_en, rd_en, start_accept, busy, done_p;
    logic [RES_W-1:0]  result;
    logic [RES_W+DATA_W-1:0] res_ext;

    mult_seq #(.OP_W(OP_W), .RES_W(RES_W)) u_core (
        .clk    (clk),
        .reset  (reset),
        .start  (start_q),
        .sgn    (sgn_q),
        .op_a   (a_q),
        .op_b   (b_q),
        .busy   (busy),
        .done_p (done_p),
        .result (result)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            ie_q    <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            d_out_q <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            ie_q    <= ie_d;
            start_q <= start_d;
            done_q  <= done_d;
            d_out_q <= d_out_d;
        end
    end

    assign wr_en   = cs & wr;
    assign rd_en   = cs & rd;
    assign res_ext = (RES_W + DATA_W)'(result);
    // A start that lands while the core is busy is dropped, so it can never
    // sneak in on the FIN->IDLE boundary.
    assign start_accept = wr_en && (addr == ADDR_CTRL) && d_in[CTRL_START] && !busy;

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        ie_d    = ie_q;
        start_d = start_accept;
        done_d  = done_q;
        d_out_d = d_out_q;
        rdata   = '0;
        if (wr_en) begin
            case (addr)
                ADDR_A:    a_d = OP_W'(d_in);
                ADDR_B:    b_d = OP_W'(d_in);
                ADDR_CTRL: begin
                    sgn_d = d_in[CTRL_SGN];
                    ie_d  = d_in[CTRL_IE];
                end
                default: ;
            endcase
        end
        if (start_accept) done_d = 1'b0;
        else if (done_p)  done_d = 1'b1;
        case (addr)
            ADDR_A:      rdata = DATA_W'(a_q);
            ADDR_B:      rdata = DATA_W'(b_q);
            ADDR_CTRL:   rdata = DATA_W'({ie_q, sgn_q, 1'b0});
            ADDR_RES_LO: rdata = DATA_W'(res_ext);
            ADDR_STATUS: rdata = DATA_W'({busy, done_q});
            ADDR_RES_HI: rdata = DATA_W'(res_ext >> DATA_W);
            default:     rdata = '0;
        endcase
        if (rd_en) d_out_d = rdata;
    end

    assign d_out = d_out_q;
    assign irq   = done_q & ie_q;
endmodule

// File: tb/tb_peripheral_mult_gen.sv
// Directed bench for peripheral_mult_gen: a 16-bit and a 32-bit operand instance
// share one bus; each scenario task checks hand-computed register values.
module tb_peripheral_mult_gen;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] d_in = '0;
    logic        cs0 = 1'b0, cs1 = 1'b0;
    logic [4:0]  addr = '0;
    logic        rd = 1'b0, wr = 1'b0;
    logic [31:0] d_out0, d_out1;
    logic        irq0, irq1;
    int          pass_cnt = 0, tot_cnt = 0;

    always #5 clk = ~clk;

    peripheral_mult_gen #(.DATA_W(32), .OP_W(16)) u16 (
        .clk(clk), .reset(reset), .d_in(d_in), .cs(cs0), .addr(addr),
        .rd(rd), .wr(wr), .d_out(d_out0), .irq(irq0));

    peripheral_mult_gen #(.DATA_W(32), .OP_W(32)) u32 (
        .clk(clk), .reset(reset), .d_in(d_in), .cs(cs1), .addr(addr),
        .rd(rd), .wr(wr), .d_out(d_out1), .irq(irq1));

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input int dev, input logic [4:0] a, input logic [31:0] d);
        cs0 = (dev == 0); cs1 = (dev == 1); wr = 1'b1; addr = a; d_in = d;
        @(posedge clk); #1;
        cs0 = 1'b0; cs1 = 1'b0; wr = 1'b0;
    endtask

    task automatic rd_reg(input int dev, input logic [4:0] a, output logic [31:0] d);
        cs0 = (dev == 0); cs1 = (dev == 1); rd = 1'b1; addr = a;
        @(posedge clk); #1;
        cs0 = 1'b0; cs1 = 1'b0; rd = 1'b0;
        d = (dev == 1) ? d_out1 : d_out0;
    endtask

    task automatic run_op(input int dev, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] ctrl, input int op_w);
        wr_reg(dev, 5'h04, a);
        wr_reg(dev, 5'h08, b);
        wr_reg(dev, 5'h0C, 32'(ctrl));
        tick(op_w + 2);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        logic [4:0]  regs [6] = '{5'h04, 5'h08, 5'h0C, 5'h10, 5'h14, 5'h18};
        tot_cnt++;
        if (d_out0 !== 32'h0 || irq0 !== 1'b0) $display("FAIL reset_out d_out=%h irq=%b exp 0/0", d_out0, irq0);
        else pass_cnt++;
        foreach (regs[i]) begin
            rd_reg(0, regs[i], v);
            tot_cnt++;
            if (v !== 32'h0) $display("FAIL reset_reg%h got %h exp 0", regs[i], v);
            else pass_cnt++;
        end
    endtask

    task automatic test_unsigned16();
        logic [31:0] v;
        wr_reg(0, 5'h04, 32'd3);
        wr_reg(0, 5'h08, 32'd5);
        wr_reg(0, 5'h0C, 32'h1);      // E0
        tick(1);
        rd_reg(0, 5'h14, v);          // E2
        tot_cnt++;
        if (v !== 32'h2) $display("FAIL u16_status_run got %h exp 2", v); else pass_cnt++;
        tick(15);
        rd_reg(0, 5'h14, v);          // E18: FIN cycle, pre-edge value
        tot_cnt++;
        if (v !== 32'h2) $display("FAIL u16_status_fin got %h exp 2", v); else pass_cnt++;
        rd_reg(0, 5'h14, v);          // E19
        tot_cnt++;
        if (v !== 32'h1) $display("FAIL u16_status_done got %h exp 1", v); else pass_cnt++;
        rd_reg(0, 5'h10, v);
        tot_cnt++;
        if (v !== 32'h0000000F) $display("FAIL u16_res_lo got %h exp 0000000f", v); else pass_cnt++;
    endtask

    task automatic test_signed16();
        logic [31:0] v;
        logic [31:0] ta [3] = '{32'hFFFD, 32'h8000, 32'h0};
        logic [31:0] tb [3] = '{32'h5, 32'h8000, 32'h8000};
        logic [31:0] te [3] = '{32'hFFFFFFF1, 32'h40000000, 32'h0};
        foreach (ta[i]) begin
            run_op(0, ta[i], tb[i], 3'b011, 16);
            rd_reg(0, 5'h10, v);
            tot_cnt++;
            if (v !== te[i]) $display("FAIL s16_res_lo[%0d] got %h exp %h", i, v, te[i]); else pass_cnt++;
        end
        rd_reg(0, 5'h18, v);
        tot_cnt++;
        if (v !== 32'h0) $display("FAIL s16_res_hi got %h exp 0", v); else pass_cnt++;
    endtask

    task automatic test_wide32();
        logic [31:0] v;
        run_op(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b001, 32);
        rd_reg(1, 5'h10, v);
        tot_cnt++;
        if (v !== 32'h00000001) $display("FAIL w32u_res_lo got %h exp 00000001", v); else pass_cnt++;
        rd_reg(1, 5'h18, v);
        tot_cnt++;
        if (v !== 32'hFFFFFFFE) $display("FAIL w32u_res_hi got %h exp fffffffe", v); else pass_cnt++;
        run_op(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b011, 32);
        rd_reg(1, 5'h10, v);
        tot_cnt++;
        if (v !== 32'h00000001) $display("FAIL w32s_res_lo got %h exp 00000001", v); else pass_cnt++;
        rd_reg(1, 5'h18, v);
        tot_cnt++;
        if (v !== 32'h0) $display("FAIL w32s_res_hi got %h exp 0", v); else pass_cnt++;
    endtask

    task automatic test_busy_restart();
        logic [31:0] v;
        wr_reg(0, 5'h04, 32'd7);
        wr_reg(0, 5'h08, 32'd9);
        wr_reg(0, 5'h0C, 32'h1);      // E0
        tick(4);                      // E4
        wr_reg(0, 5'h04, 32'd2);      // E5
        wr_reg(0, 5'h0C, 32'h1);      // E6, ignored
        tick(11);                     // E17
        rd_reg(0, 5'h14, v);          // E18
        tot_cnt++;
        if (v !== 32'h2) $display("FAIL restart_status_fin got %h exp 2", v); else pass_cnt++;
        rd_reg(0, 5'h14, v);          // E19
        tot_cnt++;
        if (v !== 32'h1) $display("FAIL restart_status_done got %h exp 1", v); else pass_cnt++;
        rd_reg(0, 5'h10, v);
        tot_cnt++;
        if (v !== 32'd63) $display("FAIL restart_res_lo got %0d exp 63", v); else pass_cnt++;
        tick(20);
        rd_reg(0, 5'h14, v);
        tot_cnt++;
        if (v !== 32'h1) $display("FAIL restart_no_second_run got %h exp 1", v); else pass_cnt++;
        rd_reg(0, 5'h04, v);
        tot_cnt++;
        if (v !== 32'd2) $display("FAIL restart_a_reg got %0d exp 2", v); else pass_cnt++;
    endtask

    task automatic test_regs_bus();
        logic [31:0] v;
        wr_reg(0, 5'h0C, 32'h6);
        rd_reg(0, 5'h0C, v);
        tot_cnt++;
        if (v !== 32'h6) $display("FAIL ctrl_read got %h exp 6", v); else pass_cnt++;
        rd_reg(0, 5'h1C, v);
        tot_cnt++;
        if (v !== 32'h0) $display("FAIL unmapped_read got %h exp 0", v); else pass_cnt++;
        wr_reg(0, 5'h04, 32'h1234);
        rd_reg(0, 5'h04, v);
        tot_cnt++;
        if (v !== 32'h1234) $display("FAIL a_write got %h exp 1234", v); else pass_cnt++;
        wr_reg(2, 5'h04, 32'h5555);   // no chip select
        rd_reg(2, 5'h10, v);          // no chip select: d_out holds
        tot_cnt++;
        if (d_out0 !== 32'h1234) $display("FAIL nocs_read_hold got %h exp 1234", d_out0); else pass_cnt++;
        rd_reg(0, 5'h04, v);
        tot_cnt++;
        if (v !== 32'h1234) $display("FAIL nocs_write_ignored got %h exp 1234", v); else pass_cnt++;
    endtask

    task automatic test_irq_reset();
        logic [31:0] v;
        wr_reg(0, 5'h04, 32'd3);
        wr_reg(0, 5'h08, 32'd5);
        wr_reg(0, 5'h0C, 32'h5);      // E0, ie=1
        tick(17);
        tot_cnt++;
        if (irq0 !== 1'b0) $display("FAIL irq_before_done got %b exp 0", irq0); else pass_cnt++;
        tick(1);                      // E18
        tot_cnt++;
        if (irq0 !== 1'b1) $display("FAIL irq_at_done got %b exp 1", irq0); else pass_cnt++;
        rd_reg(0, 5'h10, v);
        tot_cnt++;
        if (v !== 32'd15) $display("FAIL irq_res_lo got %0d exp 15", v); else pass_cnt++;
        wr_reg(0, 5'h0C, 32'h5);      // new start drops irq at E0
        tot_cnt++;
        if (irq0 !== 1'b0) $display("FAIL irq_drop got %b exp 0", irq0); else pass_cnt++;
        tick(5);
        reset = 1'b0;
        #1;
        tot_cnt++;
        if (d_out0 !== 32'h0 || irq0 !== 1'b0)
            $display("FAIL async_reset d_out=%h irq=%b exp 0/0", d_out0, irq0);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b1;
        tick(1);
        rd_reg(0, 5'h14, v);
        tot_cnt++;
        if (v !== 32'h0) $display("FAIL post_reset_status got %h exp 0", v); else pass_cnt++;
        rd_reg(0, 5'h10, v);
        tot_cnt++;
        if (v !== 32'h0) $display("FAIL post_reset_res got %h exp 0", v); else pass_cnt++;
    endtask

    initial begin
        tick(3);
        reset = 1'b1;
        tick(1);
        test_reset();
        test_unsigned16();
        test_signed16();
        test_wide32();
        test_busy_restart();
        test_regs_bus();
        test_irq_reset();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
